// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, register-index constants, address check.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package apb_pkg;

    // Encoding matches the APB master so state values read the same on both sides.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b01,
        ST_SETUP  = 2'b11,
        ST_ACCESS = 2'b10
    } apb_state_e;

    localparam int ID_REG_IDX   = 0;   // read-only identification register
    localparam int FIRST_RW_IDX = 1;   // first writable register
    localparam int WAIT_CNT_W   = 4;   // wait-state counter width (0..15)

    // An access is refused when misaligned, beyond the bank, or a write to the ID register.
    function automatic logic access_bad(input logic [1:0]  byte_off,
                                        input logic [31:0] word_idx,
                                        input logic [31:0] num_regs,
                                        input logic        is_write);
        return (byte_off != 2'b00) ||
               (word_idx >= num_regs) ||
               (is_write && (word_idx == 32'(ID_REG_IDX)));
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between the team's APB master and the register-file slave.
// Latency: n/a (wires only).
// Backpressure: pready from the slave stretches the ACCESS phase.
// Signals: psel/penable/pwrite/paddr/pwdata (master->slave), prdata/pready/pslverr (slave->master).
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_fsm.sv
// APB slave protocol FSM: phase tracking, optional wait states, pready/pslverr, bank strobes.
// Latency: setup_done fires in the SETUP cycle; write_commit in the completing ACCESS cycle.
// Backpressure: pready low for WAIT_CYCLES ACCESS cycles when APB_SLAVE_WAIT_EN is defined, else always 1.
// Ports: pclk, reset (async active-high), psel/penable/pwrite, addr_bad (combinational check of paddr),
//        pready, pslverr, setup_done, write_commit.
module apb_slave_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic pclk,
    input  logic reset,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    input  logic addr_bad,
    output logic pready,
    output logic pslverr,
    output logic setup_done,
    output logic write_commit
);

    apb_state_e state;
    apb_state_e state_nxt;
    logic       bad_q;
    logic       in_access;

    // The state register records the phase sampled at the last edge, so a live ACCESS
    // cycle is one that follows a SETUP (or a stretched ACCESS) of this transfer.
    assign setup_done = psel & ~penable;
    assign in_access  = psel & penable & ((state == ST_SETUP) || (state == ST_ACCESS));

`ifdef APB_SLAVE_WAIT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!psel) begin
            wait_cnt <= '0;                         // aborted transfer leaves no residue
        end else if (setup_done) begin
            wait_cnt <= WAIT_CNT_W'(WAIT_CYCLES);
        end else if (in_access && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign pready = ~(in_access & (wait_cnt != '0));
`else
    logic unused_wait_cycles;
    assign unused_wait_cycles = (WAIT_CYCLES != 0);
    assign pready = 1'b1;
`endif

    assign pslverr      = in_access & pready & bad_q;
    assign write_commit = in_access & pready & pwrite & ~bad_q;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            bad_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (setup_done) begin
                bad_q <= addr_bad;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (psel && !penable) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (!psel)        state_nxt = ST_IDLE;
                else if (penable) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel)         state_nxt = ST_IDLE;
                else if (!pready)  state_nxt = ST_ACCESS;
                else if (!penable) state_nxt = ST_SETUP;
                // Completed with penable still high: drop to IDLE so a held penable
                // cannot commit twice; a following SETUP is picked up from IDLE.
                else               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave register file: ID register at index 0, RW registers 1..NUM_REGS-1, exported on reg_q.
// Latency: read data registered at the end of SETUP; writes visible on reg_q the cycle after ACCESS.
// Backpressure: optional wait states (define APB_SLAVE_WAIT_EN) hold pready low for WAIT_CYCLES.
// Ports: pclk, reset (async active-high), apb (slave modport), reg_q (all registers), wr_count (good writes, wraps).
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA5B0_0001,
    parameter int                    WAIT_CYCLES = 2
) (
    input  logic                           pclk,
    input  logic                           reset,
    apb_slave_regfile_if.slave             apb,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [7:0]                     wr_count
);

    logic [DATA_WIDTH-1:0] regs [FIRST_RW_IDX:NUM_REGS-1];
    logic [31:0]           idx_w;
    logic                  addr_bad;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  setup_done;
    logic                  write_commit;

    assign idx_w    = 32'(apb.paddr[ADDR_WIDTH-1:2]);
    assign addr_bad = access_bad(apb.paddr[1:0], idx_w, 32'(NUM_REGS), apb.pwrite);

    apb_slave_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .pclk         (pclk),
        .reset        (reset),
        .psel         (apb.psel),
        .penable      (apb.penable),
        .pwrite       (apb.pwrite),
        .addr_bad     (addr_bad),
        .pready       (apb.pready),
        .pslverr      (apb.pslverr),
        .setup_done   (setup_done),
        .write_commit (write_commit)
    );

    always_comb begin
        rd_mux = '0;
        if (!addr_bad) begin
            if (idx_w == 32'(ID_REG_IDX)) begin
                rd_mux = ID_VALUE;
            end
            for (int i = FIRST_RW_IDX; i < NUM_REGS; i++) begin
                if (idx_w == 32'(i)) rd_mux = regs[i];
            end
        end
    end

    // paddr is held stable through ACCESS, so the commit decodes it directly.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            apb.prdata <= '0;
            wr_count   <= '0;
            for (int i = FIRST_RW_IDX; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (setup_done) begin
                apb.prdata <= rd_mux;
            end
            if (write_commit) begin
                wr_count <= wr_count + 8'd1;
                for (int i = FIRST_RW_IDX; i < NUM_REGS; i++) begin
                    if (idx_w == 32'(i)) regs[i] <= apb.pwdata;
                end
            end
        end
    end

    assign reg_q[ID_REG_IDX*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
    for (genvar g = FIRST_RW_IDX; g < NUM_REGS; g++) begin : g_export
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: vector table plus multi-cycle corner sequences.
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam int          AW = 8;
    localparam int          DW = 32;
    localparam int          NR = 8;
    localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif
    localparam int NV = 14;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  wrc;
    } vec_t;

    logic              pclk = 1'b0;
    logic              reset;
    logic [NR*DW-1:0]  reg_q;
    logic [7:0]        wr_count;
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [31:0]       model [NR];
    vec_t              vec [NV];

    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_slave_regfile #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .ID_VALUE    (ID),
        .WAIT_CYCLES (2)
    ) dut (
        .pclk     (pclk),
        .reset    (reset),
        .apb      (bus.slave),
        .reg_q    (reg_q),
        .wr_count (wr_count)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] slot(input int i);
        return reg_q[i*DW +: DW];
    endfunction

    // Runs SETUP then ACCESS until pready; returns at the negedge of the completing cycle
    // with the bus still in ACCESS so the caller can chain or go idle.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = wdata;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (bus.pready !== 1'b1 && waits < 20) begin
            waits++;
            @(negedge pclk);
        end
        rdata = bus.prdata;
        err   = bus.pslverr;
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge pclk); #1;
        reset = 1'b1;
        @(posedge pclk); #1;
        reset = 1'b0;
        for (int s = 0; s < NR; s++) model[s] = (s == 0) ? ID : 32'h0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          wt;

        //         wr    addr   wdata          rdata          err   wrc
        vec[0]  = '{1'b0, 8'h00, 32'h0,        ID,            1'b0, 8'd0};
        vec[1]  = '{1'b1, 8'h04, 32'hDEADBEEF, 32'h0,         1'b0, 8'd1};
        vec[2]  = '{1'b0, 8'h04, 32'h0,        32'hDEADBEEF,  1'b0, 8'd1};
        vec[3]  = '{1'b1, 8'h00, 32'h11111111, 32'h0,         1'b1, 8'd1};
        vec[4]  = '{1'b1, 8'h20, 32'h22222222, 32'h0,         1'b1, 8'd1};
        vec[5]  = '{1'b0, 8'h06, 32'h0,        32'h0,         1'b1, 8'd1};
        vec[6]  = '{1'b0, 8'h20, 32'h0,        32'h0,         1'b1, 8'd1};
        vec[7]  = '{1'b1, 8'h1C, 32'hCAFEF00D, 32'h0,         1'b0, 8'd2};
        vec[8]  = '{1'b0, 8'h1C, 32'h0,        32'hCAFEF00D,  1'b0, 8'd2};
        vec[9]  = '{1'b1, 8'h08, 32'h00001234, 32'h0,         1'b0, 8'd3};
        vec[10] = '{1'b0, 8'h08, 32'h0,        32'h00001234,  1'b0, 8'd3};
        vec[11] = '{1'b0, 8'h00, 32'h0,        ID,            1'b0, 8'd3};
        vec[12] = '{1'b1, 8'h06, 32'h33333333, 32'h0,         1'b1, 8'd3};
        vec[13] = '{1'b0, 8'h04, 32'h0,        32'hDEADBEEF,  1'b0, 8'd3};

        for (int s = 0; s < NR; s++) model[s] = (s == 0) ? ID : 32'h0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge pclk);
        #1;

        // Reset state
        check("rst prdata",   bus.prdata,  32'h0);
        check("rst pslverr",  bus.pslverr, 32'h0);
        check("rst pready",   bus.pready,  32'h1);
        check("rst wr_count", wr_count,    32'h0);
        check("rst slot0",    slot(0),     ID);
        check("rst slot1",    slot(1),     32'h0);
        check("rst state",    32'(dut.u_fsm.state), 32'(ST_IDLE));
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            xfer(vec[i].wr, vec[i].addr, vec[i].wdata, rd, er, wt);
            check($sformatf("vec%0d pslverr", i), er, vec[i].err);
            check($sformatf("vec%0d waits", i), wt, EXP_WAITS);
            if (!vec[i].wr) check($sformatf("vec%0d prdata", i), rd, vec[i].rdata);
            if (vec[i].wr && !vec[i].err)
                check($sformatf("vec%0d reg_q before commit", i),
                      slot(int'(vec[i].addr[7:2])), model[int'(vec[i].addr[7:2])]);
            bus_idle();
            if (vec[i].wr && !vec[i].err) model[int'(vec[i].addr[7:2])] = vec[i].wdata;
            #1;
            check($sformatf("vec%0d pslverr idle", i), bus.pslverr, 32'h0);
            check($sformatf("vec%0d wr_count", i), wr_count, vec[i].wrc);
            for (int s = 0; s < NR; s++)
                check($sformatf("vec%0d slot%0d", i, s), slot(s), model[s]);
        end

        // Back-to-back writes with no IDLE, then 256 more to show wr_count wrapping
        pulse_reset();
        xfer(1'b1, 8'h04, 32'hAAAA0001, rd, er, wt);
        check("b2b0 pslverr", er, 32'h0);
        xfer(1'b1, 8'h08, 32'hAAAA0002, rd, er, wt);
        check("b2b1 pslverr", er, 32'h0);
        xfer(1'b1, 8'h0C, 32'hAAAA0003, rd, er, wt);
        check("b2b2 pslverr", er, 32'h0);
        check("b2b2 waits", wt, EXP_WAITS);
        bus_idle();
        #1;
        check("b2b wr_count", wr_count, 32'd3);
        check("b2b slot1", slot(1), 32'hAAAA0001);
        check("b2b slot2", slot(2), 32'hAAAA0002);
        check("b2b slot3", slot(3), 32'hAAAA0003);
        check("b2b slot7 cleared", slot(7), 32'h0);
        for (int n = 0; n < 256; n++) xfer(1'b1, 8'h10, 32'(n), rd, er, wt);
        bus_idle();
        #1;
        check("wrap wr_count", wr_count, 32'd3);
        check("wrap slot4", slot(4), 32'd255);

        // psel dropped before completion: no write, no error, back to IDLE
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h14; bus.pwdata = 32'h55555555;
`ifdef APB_SLAVE_WAIT_EN
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        check("abort pready in wait", bus.pready, 32'h0);
        check("abort pslverr in wait", bus.pslverr, 32'h0);
`endif
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        @(negedge pclk);
        check("abort pready", bus.pready, 32'h1);
        check("abort pslverr", bus.pslverr, 32'h0);
        @(posedge pclk); #1;
        check("abort slot5", slot(5), 32'h0);
        check("abort wr_count", wr_count, 32'd3);
        check("abort state", 32'(dut.u_fsm.state), 32'(ST_IDLE));

        // Reset asserted in the ACCESS cycle of a write to 0x0C
        pulse_reset();
        xfer(1'b1, 8'h04, 32'h0BAD0001, rd, er, wt);
        bus_idle();
        #1;
        check("pre-reset wr_count", wr_count, 32'd1);
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h0C; bus.pwdata = 32'h77777777;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("midrst wr_count", wr_count, 32'h0);
        check("midrst prdata", bus.prdata, 32'h0);
        check("midrst pready", bus.pready, 32'h1);
        check("midrst pslverr", bus.pslverr, 32'h0);
        check("midrst slot1", slot(1), 32'h0);
        check("midrst state", 32'(dut.u_fsm.state), 32'(ST_IDLE));
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        reset = 1'b0;
        @(negedge pclk);
        check("midrst slot3", slot(3), 32'h0);
        check("midrst wr_count after", wr_count, 32'h0);
        check("midrst slot0", slot(0), ID);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB slave that terminates the bus driven by the team's APB master and exposes a small bank of memory-mapped registers to the IP. It decodes `psel`/`penable`/`pwrite`/`paddr`/`pwdata`, commits writes, returns registered read data on `prdata`, flags illegal accesses on `pslverr`, and can optionally insert wait states through `pready`. Register contents are exported in parallel on `reg_q` for the downstream IP.

## Interface
- `ADDR_WIDTH`, 8: APB byte-address width.
- `DATA_WIDTH`, 32: APB data width, and the width of each register.
- `NUM_REGS`, 8: register count, 2..2^(ADDR_WIDTH-2); word index = `paddr[ADDR_WIDTH-1:2]`.
- `ID_VALUE`, 32'hA5B0_0001: constant returned by read-only register 0.
- `WAIT_CYCLES`, 2: wait states per access when the wait feature is compiled in; range 0..15.

Ports:
- `pclk`  in  1  clock; all state on the rising edge.
- `reset`  in  1  **one clock; reset is asynchronous and active-high**.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `prdata`  out  DATA_WIDTH  read data, registered.
- `pready`  out  1  transfer-complete qualifier.
- `pslverr`  out  1  error response, valid only when `pready`=1 in ACCESS.
- `reg_q`  out  NUM_REGS*DATA_WIDTH  all registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_count`  out  8  number of completed good writes, wraps 255→0.

## Operation
- FSM states:
  - IDLE: `psel`=0.
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
- FSM transitions:
  - IDLE→SETUP on `psel & !penable`.
  - SETUP→ACCESS on `psel & penable`.
  - ACCESS→SETUP on `pready & psel & !penable` (back-to-back transfer).
  - ACCESS→IDLE on `pready & !psel`.
  - ACCESS holds while `!pready`.
  - Any state→IDLE if `psel`=0.
  - `penable` without `psel` is ignored.
- Address check during SETUP:
  - `bad` = `paddr[1:0]`≠0 or word index ≥ NUM_REGS; latched at the end of SETUP.
  - A write to index 0 is also bad.
- Write:
  - Commits on the edge ending the completing ACCESS cycle (`psel & penable & pready & pwrite & !bad`).
  - `wr_count` increments at the same edge.
  - Bad writes modify nothing.
- Read:
  - `prdata` loads the selected register at the edge ending SETUP.
  - Index 0 returns ID_VALUE.
  - A bad read loads 0.
  - `prdata` holds its value until the next SETUP.
- `pslverr` = `bad` latch, gated by ACCESS & `pready`; 0 otherwise.
- Registers 1..NUM_REGS-1 are RW.

## Timing
- Reset values:
  - `prdata`=0, `pslverr`=0, `pready`=1, `wr_count`=0.
  - All RW registers 0; `reg_q` shows ID_VALUE in slot 0 and 0 elsewhere.
  - State = IDLE, wait counter = 0.
- Zero-wait transfer:
  - SETUP cycle, then one ACCESS cycle with `pready`=1.
  - Read data is valid throughout ACCESS; write is visible on `reg_q` in the cycle after ACCESS.
- `pready` is combinational from state and the wait counter: 0 in ACCESS while counter≠0, 1 otherwise.
- `psel` dropped mid-ACCESS before `pready`: abort, no write, back to IDLE. `pslverr` stays 0.
- Reset asserted mid-transfer: immediate return to reset values. Any in-flight write is lost.
- Simultaneous write to index k and `reg_q` sampling in the same cycle: `reg_q` shows the old value.

## Configuration
- `APB_SLAVE_WAIT_EN` defined:
  - 4-bit counter loads WAIT_CYCLES at the edge ending SETUP.
  - It decrements each ACCESS cycle while nonzero.
  - `pready`=0 for exactly WAIT_CYCLES ACCESS cycles, so an access takes 1+WAIT_CYCLES+1 cycles in total.
- Not defined:
  - No counter is built; `pready` is tied to 1 and WAIT_CYCLES is ignored.
  - Every transfer is SETUP + one ACCESS cycle.

## Structure
- Shared package `apb_pkg`:
  - FSM state encoding (IDLE=1, SETUP=3, ACCESS=2, matching the master's encoding).
  - Register-index constants and the ID register index (0).
- One sub-module, `apb_slave_fsm`:
  - Contains the state register, the wait counter and the `pready`/`pslverr` generation.
  - Emits `setup_done` and `write_commit` strobes to the register bank in the top level.

## Test plan
- Reset, then read addr 0x00 → `prdata`=32'hA5B0_0001, `pslverr`=0, and `reg_q` slot 0 = ID_VALUE.
- Write 0xDEAD_BEEF to 0x04, then read 0x04 → `prdata`=0xDEAD_BEEF, `wr_count`=1, `reg_q` slot 1 updated one cycle after ACCESS.
- Write to 0x00, write to 0x20 (index 8), and read 0x06 (misaligned) → `pslverr`=1 in each ACCESS, no register change, read `prdata`=0, `wr_count` unchanged.
- With `APB_SLAVE_WAIT_EN` and WAIT_CYCLES=2, write 0x1234 to 0x08 → `pready` low for 2 ACCESS cycles, commit on the 3rd.
- Back-to-back writes to 0x04, 0x08, 0x0C with no IDLE between them → all three commit and `wr_count`=3. Then issue 256 more writes → `wr_count` wraps to 3.
- Assert `reset` in the ACCESS cycle of a write to 0x0C → register stays 0, all outputs return to reset values asynchronously, and the FSM is in IDLE.
